// File: rtl/spi_axi_pkg.sv
// Shared definitions for the SPI-to-AXI4-Lite command front end.
// Holds the default opcodes, the decoder FSM state encoding, the turnaround
// length and the fill pattern shifted out when read data arrives too late.
package spi_axi_pkg;

  // Default single-transaction opcodes (overridable on the top level).
  localparam logic [7:0] CMD_WRITE_OPC = 8'h02;
  localparam logic [7:0] CMD_READ_OPC  = 8'h03;

  // Dead byte between the read address and the returned data.
  localparam int TURN_BYTES = 1;
  localparam int TURN_BITS  = 8 * TURN_BYTES;

  // Replicated across the data width when the read has not completed in time.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WR_WAIT,
    ST_TURN,
    ST_RDATA,
    ST_DRAIN
  } state_t;

  // Longest serial field; sizes the shared receive register and bit counter.
  function automatic int max_field_bits(input int aw, input int dw);
    int m;
    m = TURN_BITS;
    if (aw > m) m = aw;
    if (dw > m) m = dw;
    if (8 > m) m = 8;
    return m;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the AXI clock domain.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   sclk_raw, cs_n_raw,
//   mosi_raw               SPI pins straight from the package
//   cs_n, mosi             synchronised levels
//   sclk_rise, sclk_fall   one-cycle pulses on synchronised SCLK edges
//   cs_rise, cs_fall       one-cycle pulses on synchronised chip-select edges
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_raw,
  input  logic cs_n_raw,
  input  logic mosi_raw,
  output logic cs_n,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sclk_prev;
  logic                   cs_prev;

  // Synchroniser chains plus one extra flop per clock-like pin for edge
  // detection. Chip select resets to its idle (high) level so releasing
  // reset with the bus idle never looks like a frame start. MOSI goes
  // through the same depth as SCLK so a sampled bit lines up with its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk_raw};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n_raw};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi_raw};
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
    end
  end

  assign cs_n      = cs_pipe[SYNC_STAGES-1];
  assign mosi      = mosi_pipe[SYNC_STAGES-1];
  assign sclk_rise =  sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_pipe[SYNC_STAGES-1] &  sclk_prev;
  assign cs_rise   =  cs_pipe[SYNC_STAGES-1]   & ~cs_prev;
  assign cs_fall   = ~cs_pipe[SYNC_STAGES-1]   &  cs_prev;

endmodule

// File: rtl/spi_slave_cmd_decoder.sv
// SPI mode-0 slave that decodes command frames into single AXI4-Lite
// transactions on the companion AXI master block.
//   write frame: CMD, ADDR[AW/8], WDATA[DW/8]
//   read frame : CMD, ADDR[AW/8], TURN, RDATA[DW/8] (returned on MISO)
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN        clock, asynchronous active-low reset
//   spi_sclk, spi_cs_n, spi_mosi     SPI inputs (oversampled)
//   spi_miso                         SPI output, zero outside read data
//   init_w_axi_txn, init_r_axi_txn   one-cycle launch pulses
//   user_awaddr, user_araddr,
//   user_wdata                       held from launch until the next launch
//   user_rdata, done_*, error_*      completion side of the AXI master
//   busy                             frame in progress or txn outstanding
//   frame_err                        bad opcode, short frame, late read, bus error
module spi_slave_cmd_decoder
  import spi_axi_pkg::*;
#(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 32,
  parameter int         SYNC_STAGES        = 2,
  parameter logic [7:0] CMD_WRITE          = CMD_WRITE_OPC,
  parameter logic [7:0] CMD_READ           = CMD_READ_OPC
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          spi_sclk,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          init_w_axi_txn,
  output logic                          init_r_axi_txn,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] user_awaddr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] user_araddr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] user_wdata,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] user_rdata,
  input  logic                          done_w_axi_txn,
  input  logic                          done_r_axi_txn,
  input  logic                          error_w_axi_txn,
  input  logic                          error_r_axi_txn,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int MAXW  = max_field_bits(AW, DW);
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (M_AXI_ACLK),
    .rst_n    (M_AXI_ARESETN),
    .sclk_raw (spi_sclk),
    .cs_n_raw (spi_cs_n),
    .mosi_raw (spi_mosi),
    .cs_n     (cs_n_s),
    .mosi     (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  state_t             state, state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   field_last_idx;
  logic [MAXW-2:0]    rx_sreg;
  logic [MAXW-1:0]    rx_next;
  logic [DW-1:0]      tx_sreg;
  logic [DW-1:0]      tx_fill;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      rdata_q;
  logic               miso_q;
  logic               is_rd;
  logic               pending;
  logic               pending_rd;
  logic               rd_done_seen;
  logic               ignore_frame;
  logic               frame_err_q;

  logic field_done, opcode_ok, done_w_ok, done_r_ok, rd_result_ok;
  logic cnt_clr, cmd_cap, addr_cap, launch_w, launch_r, tx_load, err_set, ignore_set;

  // The bit arriving on this rise is appended here so a completed field can
  // be captured on the same cycle as its last bit.
  assign rx_next    = {rx_sreg, mosi_s};
  assign field_done = sclk_rise && !cs_n_s && (bit_cnt == field_last_idx);
  assign opcode_ok  = (rx_next[7:0] == CMD_WRITE) || (rx_next[7:0] == CMD_READ);

  // Completions only count against the transaction actually outstanding.
  assign done_w_ok    = pending && !pending_rd && done_w_axi_txn;
  assign done_r_ok    = pending &&  pending_rd && done_r_axi_txn;
  assign rd_result_ok = rd_done_seen || done_r_ok;

  // Read data for the RDATA phase: prefer a completion landing on the very
  // cycle TURN ends, then an earlier latched one, else the timeout fill.
  always_comb begin
    tx_fill = {DW{TIMEOUT_FILL_BIT}};
    if (done_r_ok)
      tx_fill = user_rdata;
    else if (rd_done_seen)
      tx_fill = rdata_q;
  end

  // Index of the final bit of the field the FSM is currently collecting.
  always_comb begin
    field_last_idx = CNT_W'(7);
    case (state)
      ST_ADDR:            field_last_idx = CNT_W'(AW - 1);
      ST_WDATA, ST_RDATA: field_last_idx = CNT_W'(DW - 1);
      ST_TURN:            field_last_idx = CNT_W'(TURN_BITS - 1);
      default:            field_last_idx = CNT_W'(7);
    endcase
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Frame sequencing. A chip-select rise always wins over a coincident
  // field completion. Dropping the frame before the launch point is an
  // error; dropping it after launch just lets the transaction finish
  // unobserved. A frame that starts while a txn is still outstanding is
  // parked in DRAIN and flagged when it ends.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cmd_cap    = 1'b0;
    addr_cap   = 1'b0;
    launch_w   = 1'b0;
    launch_r   = 1'b0;
    tx_load    = 1'b0;
    err_set    = 1'b0;
    ignore_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          cnt_clr = 1'b1;
          if (pending) begin
            state_next = ST_DRAIN;
            ignore_set = 1'b1;
          end else begin
            state_next = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else if (field_done) begin
          cnt_clr = 1'b1;
          if (opcode_ok) begin
            state_next = ST_ADDR;
            cmd_cap    = 1'b1;
          end else begin
            state_next = ST_DRAIN;
            err_set    = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else if (field_done) begin
          cnt_clr  = 1'b1;
          addr_cap = 1'b1;
          if (is_rd) begin
            state_next = ST_TURN;
            launch_r   = 1'b1;
          end else begin
            state_next = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else if (field_done) begin
          cnt_clr    = 1'b1;
          launch_w   = 1'b1;
          state_next = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (cs_rise)
          state_next = ST_IDLE;
        else if (done_w_ok)
          state_next = ST_DRAIN;
      end
      ST_TURN: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (field_done) begin
          cnt_clr    = 1'b1;
          tx_load    = 1'b1;
          state_next = ST_RDATA;
          if (!rd_result_ok)
            err_set = 1'b1;
        end
      end
      ST_RDATA: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (field_done) begin
          cnt_clr    = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          err_set    = ignore_frame;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Receive path: bit counter, input shift register and captured fields.
  // The counter is held at zero while chip select is high.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      bit_cnt <= '0;
      rx_sreg <= '0;
      is_rd   <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (cs_n_s || cnt_clr)
        bit_cnt <= '0;
      else if (sclk_rise)
        bit_cnt <= bit_cnt + CNT_W'(1);
      if (sclk_rise && !cs_n_s)
        rx_sreg <= rx_next[MAXW-2:0];
      if (cmd_cap)
        is_rd <= (rx_next[7:0] == CMD_READ);
      if (addr_cap)
        addr_q <= rx_next[AW-1:0];
    end
  end

  // AXI request side: launch pulses, held request buses and the single
  // outstanding-transaction tracker with its read-data latch.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      init_w_axi_txn <= 1'b0;
      init_r_axi_txn <= 1'b0;
      user_awaddr    <= '0;
      user_araddr    <= '0;
      user_wdata     <= '0;
      pending        <= 1'b0;
      pending_rd     <= 1'b0;
      rd_done_seen   <= 1'b0;
      rdata_q        <= '0;
    end else begin
      init_w_axi_txn <= launch_w;
      init_r_axi_txn <= launch_r;
      if (launch_w) begin
        user_awaddr <= addr_q;
        user_wdata  <= rx_next[DW-1:0];
      end
      if (launch_r)
        user_araddr <= rx_next[AW-1:0];
      if (launch_w || launch_r) begin
        pending    <= 1'b1;
        pending_rd <= launch_r;
      end else if (done_w_ok || done_r_ok) begin
        pending <= 1'b0;
      end
      if (launch_r)
        rd_done_seen <= 1'b0;
      else if (done_r_ok)
        rd_done_seen <= 1'b1;
      if (done_r_ok)
        rdata_q <= user_rdata;
    end
  end

  // Transmit path. MISO only carries data during RDATA; each SCLK fall
  // presents the next bit, so the word loaded at the end of TURN has its
  // MSB on the line before the first RDATA rise.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      tx_sreg <= '0;
      miso_q  <= 1'b0;
    end else if (cs_n_s) begin
      miso_q <= 1'b0;
    end else if (tx_load) begin
      tx_sreg <= tx_fill;
    end else if (sclk_fall) begin
      if (state == ST_RDATA) begin
        miso_q  <= tx_sreg[DW-1];
        tx_sreg <= {tx_sreg[DW-2:0], 1'b0};
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  // Error pulse and frame flags. Bus errors are reported combinationally so
  // they line up with the completion that carries them.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      frame_err_q  <= 1'b0;
      ignore_frame <= 1'b0;
    end else begin
      frame_err_q <= err_set;
      if (ignore_set)
        ignore_frame <= 1'b1;
      else if (cs_rise)
        ignore_frame <= 1'b0;
    end
  end

  assign spi_miso  = miso_q;
  assign busy      = (state != ST_IDLE) || pending;
  assign frame_err = frame_err_q
                   | (done_w_ok & error_w_axi_txn)
                   | (done_r_ok & error_r_axi_txn);

endmodule

// File: tb/tb_spi_slave_cmd_decoder.sv
// Directed bench for spi_slave_cmd_decoder: drives SPI mode-0 frames, plays
// the AXI master's completion side by hand and checks launch pulses,
// request buses, MISO data, busy and frame_err against hand-computed values.
module tb_spi_slave_cmd_decoder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs_n, mosi, miso;
  logic        init_w, init_r;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic        done_w, done_r, err_w, err_r;
  logic        busy, frame_err;

  int total = 0;
  int bad   = 0;

  int          init_w_cnt = 0;
  int          init_r_cnt = 0;
  int          ferr_cnt   = 0;
  logic [31:0] cap_awaddr = '0;
  logic [31:0] cap_wdata  = '0;
  logic [31:0] cap_araddr = '0;

  always #5 clk = ~clk;

  spi_slave_cmd_decoder dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESETN  (rst_n),
    .spi_sclk       (sclk),
    .spi_cs_n       (cs_n),
    .spi_mosi       (mosi),
    .spi_miso       (miso),
    .init_w_axi_txn (init_w),
    .init_r_axi_txn (init_r),
    .user_awaddr    (awaddr),
    .user_araddr    (araddr),
    .user_wdata     (wdata),
    .user_rdata     (rdata),
    .done_w_axi_txn (done_w),
    .done_r_axi_txn (done_r),
    .error_w_axi_txn(err_w),
    .error_r_axi_txn(err_r),
    .busy           (busy),
    .frame_err      (frame_err)
  );

  // Pulse monitor: counts high cycles of each strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (init_w) begin
      init_w_cnt = init_w_cnt + 1;
      cap_awaddr = awaddr;
      cap_wdata  = wdata;
    end
    if (init_r) begin
      init_r_cnt = init_r_cnt + 1;
      cap_araddr = araddr;
    end
    if (frame_err)
      ferr_cnt = ferr_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One SPI byte, MSB first; MISO is sampled just before each rising edge.
  task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx[i] = miso;
      sclk  = 1'b1;
      tick(HALF);
      sclk  = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, output logic [31:0] r);
    logic [7:0] b;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(w[i*8 +: 8], b);
      r = {r[23:0], b};
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic pulse_done_w(input logic e);
    done_w = 1'b1;
    err_w  = e;
    tick(1);
    done_w = 1'b0;
    err_w  = 1'b0;
    tick(2);
  endtask

  task automatic pulse_done_r(input logic [31:0] d, input logic e);
    rdata  = d;
    done_r = 1'b1;
    err_r  = e;
    tick(1);
    done_r = 1'b0;
    err_r  = 1'b0;
    rdata  = '0;
    tick(2);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] r;
    int w0, r0, e0;

    rst_n = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rdata = '0; done_w = 1'b0; done_r = 1'b0; err_w = 1'b0; err_r = 1'b0;
    tick(4);
    checkOutput("reset_ctrl", {busy, init_w, init_r, frame_err, miso}, 5'b0);
    checkOutput("reset_bus", {awaddr, wdata}, 64'h0);
    rst_n = 1'b1;
    tick(4);

    // 1: plain write
    $display("[TB] write frame");
    w0 = init_w_cnt; r0 = init_r_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h02, b);
    send_word(32'h4000_0010, r);
    send_word(32'hA5A5_1234, r);
    checkOutput("wr_miso", r, 32'h0);
    checkOutput("wr_init_w", init_w_cnt - w0, 1);
    checkOutput("wr_init_r", init_r_cnt - r0, 0);
    checkOutput("wr_awaddr", cap_awaddr, 32'h4000_0010);
    checkOutput("wr_wdata", cap_wdata, 32'hA5A5_1234);
    checkOutput("wr_busy_pend", busy, 1'b1);
    pulse_done_w(1'b0);
    frame_end();
    checkOutput("wr_busy_done", busy, 1'b0);
    checkOutput("wr_ferr", ferr_cnt - e0, 0);

    // 2: read with completion during TURN
    $display("[TB] read frame");
    w0 = init_w_cnt; r0 = init_r_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h03, b);
    send_word(32'h4000_0020, r);
    checkOutput("rd_init_r", init_r_cnt - r0, 1);
    checkOutput("rd_araddr", cap_araddr, 32'h4000_0020);
    pulse_done_r(32'hCAFE_F00D, 1'b0);
    applyStimulus(8'h00, b);
    checkOutput("rd_turn", b, 8'h00);
    send_word(32'h0, r);
    checkOutput("rd_data", r, 32'hCAFE_F00D);
    frame_end();
    checkOutput("rd_busy", busy, 1'b0);
    checkOutput("rd_ferr", ferr_cnt - e0, 0);
    checkOutput("rd_init_w", init_w_cnt - w0, 0);

    // 3: read whose completion misses TURN
    $display("[TB] late read frame");
    e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h03, b);
    send_word(32'h4000_0030, r);
    applyStimulus(8'h00, b);
    send_word(32'h0, r);
    checkOutput("late_data", r, 32'hFFFF_FFFF);
    frame_end();
    checkOutput("late_ferr", ferr_cnt - e0, 1);
    checkOutput("late_busy_pend", busy, 1'b1);
    pulse_done_r(32'h1234_5678, 1'b0);
    checkOutput("late_busy_done", busy, 1'b0);

    // 4: unknown opcode
    $display("[TB] bad opcode frame");
    w0 = init_w_cnt; r0 = init_r_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h7E, b);
    checkOutput("bad_miso_cmd", b, 8'h00);
    send_word(32'h4000_0010, r);
    checkOutput("bad_miso_tail", r, 32'h0);
    frame_end();
    checkOutput("bad_init", {init_w_cnt - w0, init_r_cnt - r0}, 64'h0);
    checkOutput("bad_ferr", ferr_cnt - e0, 1);
    checkOutput("bad_busy", busy, 1'b0);

    // 5a: write frame cut short in the address
    $display("[TB] short write frame");
    w0 = init_w_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h02, b);
    applyStimulus(8'h40, b);
    applyStimulus(8'h00, b);
    frame_end();
    checkOutput("short_init_w", init_w_cnt - w0, 0);
    checkOutput("short_ferr", ferr_cnt - e0, 1);
    checkOutput("short_busy", busy, 1'b0);

    // 5b: read aborted in TURN, then a frame arriving while still pending
    $display("[TB] aborted read and overlapping frame");
    r0 = init_r_cnt;
    frame_begin();
    applyStimulus(8'h03, b);
    send_word(32'h4000_0060, r);
    frame_end();
    checkOutput("abort_init_r", init_r_cnt - r0, 1);
    checkOutput("abort_araddr", cap_araddr, 32'h4000_0060);
    checkOutput("abort_busy", busy, 1'b1);
    r0 = init_r_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h03, b);
    send_word(32'h4000_0070, r);
    applyStimulus(8'h00, b);
    send_word(32'h0, r);
    checkOutput("ovl_miso", r, 32'h0);
    frame_end();
    checkOutput("ovl_init_r", init_r_cnt - r0, 0);
    checkOutput("ovl_ferr", ferr_cnt - e0, 1);
    checkOutput("ovl_busy", busy, 1'b1);
    pulse_done_r(32'h0BAD_0BAD, 1'b0);
    checkOutput("abort_busy_done", busy, 1'b0);

    // stray completions with nothing outstanding
    e0 = ferr_cnt;
    pulse_done_w(1'b1);
    pulse_done_r(32'hFFFF_0000, 1'b1);
    checkOutput("stray_ferr", ferr_cnt - e0, 0);
    checkOutput("stray_busy", busy, 1'b0);

    // write completing with a bus error
    $display("[TB] write with bus error");
    e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h02, b);
    send_word(32'h4000_0050, r);
    send_word(32'h0000_0001, r);
    pulse_done_w(1'b1);
    frame_end();
    checkOutput("werr_ferr", ferr_cnt - e0, 1);

    // 6: reset in the middle of write data, then a clean write
    $display("[TB] reset mid frame");
    frame_begin();
    applyStimulus(8'h02, b);
    send_word(32'h4000_0080, r);
    applyStimulus(8'h11, b);
    applyStimulus(8'h22, b);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", {busy, init_w, init_r, frame_err, miso}, 5'b0);
    checkOutput("rst_mid_bus", {awaddr, araddr}, 64'h0);
    checkOutput("rst_mid_wdata", wdata, 32'h0);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    w0 = init_w_cnt; e0 = ferr_cnt;
    frame_begin();
    applyStimulus(8'h02, b);
    send_word(32'h4000_0040, r);
    send_word(32'h1122_3344, r);
    checkOutput("post_rst_init_w", init_w_cnt - w0, 1);
    checkOutput("post_rst_addr", cap_awaddr, 32'h4000_0040);
    checkOutput("post_rst_data", cap_wdata, 32'h1122_3344);
    pulse_done_w(1'b0);
    frame_end();
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_ferr", ferr_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
